// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike rate decoder.
package spike_pkg;

   localparam int unsigned WINDOW_W_DEF = 8;
   localparam int unsigned COUNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StCount,
      StHold
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [Width-1:0] count,
   output logic             sat
);

   logic [Width-1:0] count_q;

   assign count = count_q;
   assign sat   = &count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (inc && !sat) begin
         count_q <= count_q + Width'(1);
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a programmable window and reports the rate and, when
// SPIKE_RATE_DECODER_ISI_EN is defined, the minimum inter-spike interval.
module spike_rate_decoder
   import spike_pkg::*;
#(
   parameter int unsigned WINDOW_W = WINDOW_W_DEF,
   parameter int unsigned COUNT_W  = COUNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                spike_in,
   input  logic                start,
   input  logic [WINDOW_W-1:0] window_len,
   output logic                busy,
   output logic [COUNT_W-1:0]  rate_out,
   output logic [COUNT_W-1:0]  isi_min,
   output logic                valid,
   input  logic                ready
);

   state_e              state_q, state_d;
   logic [WINDOW_W-1:0] remain_q, remain_d;
   logic [COUNT_W-1:0]  rate_q, rate_d;
   logic [COUNT_W-1:0]  spike_cnt, count_next;
   logic                spike_sat;
   logic                accept, sample, spike, last;

   assign accept = (state_q == StIdle) && start;
   assign sample = (state_q == StCount);
   assign spike  = sample && spike_in;
   assign last   = sample && (remain_q == WINDOW_W'(1));

   sat_counter #(
      .Width(COUNT_W)
   ) u_spike_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(accept),
      .inc  (spike),
      .count(spike_cnt),
      .sat  (spike_sat)
   );

   // Result must include a spike on the final sample, so look one step ahead.
   assign count_next = (spike && !spike_sat) ? spike_cnt + COUNT_W'(1) : spike_cnt;

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      rate_d   = rate_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StCount;
               remain_d = (window_len == '0) ? WINDOW_W'(1) : window_len;
            end
         end
         StCount: begin
            if (remain_q == WINDOW_W'(1)) begin
               state_d = StHold;
               rate_d  = count_next;
            end else begin
               remain_d = remain_q - WINDOW_W'(1);
            end
         end
         StHold: begin
            if (ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         remain_q <= '0;
         rate_q   <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         rate_q   <= rate_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign valid    = (state_q == StHold);
   assign rate_out = rate_q;

`ifdef SPIKE_RATE_DECODER_ISI_EN
   logic               have_q;
   logic [COUNT_W-1:0] gap, isi_now, min_q, min_next, isi_q;
   logic               gap_sat;

   // Gap counts non-spike samples since the previous spike.
   sat_counter #(
      .Width(COUNT_W)
   ) u_gap_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(accept || spike),
      .inc  (sample && !spike_in),
      .count(gap),
      .sat  (gap_sat)
   );

   assign isi_now  = gap_sat ? '1 : gap + COUNT_W'(1);
   assign min_next = (spike && have_q && (isi_now < min_q)) ? isi_now : min_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         have_q <= 1'b0;
         min_q  <= '1;
         isi_q  <= '1;
      end else if (accept) begin
         have_q <= 1'b0;
         min_q  <= '1;
      end else if (sample) begin
         if (spike_in) begin
            have_q <= 1'b1;
         end
         min_q <= min_next;
         if (last) begin
            isi_q <= min_next;
         end
      end
   end

   assign isi_min = isi_q;
`else
   assign isi_min = '1;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed scoreboard bench for spike_rate_decoder; honours SPIKE_RATE_DECODER_ISI_EN.
module tb_spike_rate_decoder;

   typedef struct {
      logic [7:0] rate;
      logic [7:0] isi;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, spike_in, start, ready;
   logic [7:0] window_len;
   logic       busy, valid;
   logic [7:0] rate_out, isi_min;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   spike_rate_decoder #(
      .WINDOW_W(8),
      .COUNT_W (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .spike_in  (spike_in),
      .start     (start),
      .window_len(window_len),
      .busy      (busy),
      .rate_out  (rate_out),
      .isi_min   (isi_min),
      .valid     (valid),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: spike count and minimum inter-spike interval.
   function automatic exp_t model(input int len, input logic [255:0] pat);
      exp_t e;
      int   n, cnt, prev, mn, d;
      n    = (len == 0) ? 1 : len;
      cnt  = 0;
      prev = -1;
      mn   = 255;
      for (int i = 0; i < n; i++) begin
         if (pat[i]) begin
            if (cnt < 255) cnt++;
            if (prev >= 0) begin
               d = i - prev;
               if (d > 255) d = 255;
               if (d < mn) mn = d;
            end
            prev = i;
         end
      end
      e.rate = 8'(cnt);
`ifdef SPIKE_RATE_DECODER_ISI_EN
      e.isi = 8'(mn);
`else
      e.isi = 8'hff;
`endif
      return e;
   endfunction

   // Entered #1 after an edge with the DUT idle; spikes are driven high
   // whenever the DUT must ignore them, and start is held high through HOLD.
   task automatic run_window(input int len, input logic [255:0] pat, input int hold);
      int   n, waited;
      exp_t got;
      n = (len == 0) ? 1 : len;
      sb.push_back(model(len, pat));
      start      = 1'b1;
      window_len = len[7:0];
      spike_in   = 1'b1;
      ready      = 1'b0;
      tick();
      start = 1'b0;
      check("busy_in_count", {31'd0, busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
         spike_in = pat[i];
         tick();
      end
      spike_in = 1'b1;
      waited   = 0;
      while (!valid && waited < 300) begin
         tick();
         waited++;
      end
      check("valid_latency", waited, 0);
      got = sb.pop_front();
      if (valid === 1'b1) begin
         for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            check("hold_valid", {31'd0, valid}, 32'd1);
            check("hold_rate", {24'd0, rate_out}, {24'd0, got.rate});
            check("hold_isi", {24'd0, isi_min}, {24'd0, got.isi});
            tick();
         end
         start = 1'b1;
         ready = 1'b1;
         check("rate_out", {24'd0, rate_out}, {24'd0, got.rate});
         check("isi_min", {24'd0, isi_min}, {24'd0, got.isi});
         tick();
         start    = 1'b0;
         ready    = 1'b0;
         spike_in = 1'b0;
         check("idle_valid", {31'd0, valid}, 32'd0);
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_rate_held", {24'd0, rate_out}, {24'd0, got.rate});
         tick();
         check("start_not_queued", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      logic [255:0] pat;
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] pat;
      reset      = 1'b1;
      spike_in   = 1'b0;
      start      = 1'b0;
      ready      = 1'b0;
      window_len = 8'd0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_rate", {24'd0, rate_out}, 32'd0);
      check("rst_isi", {24'd0, isi_min}, 32'hff);
      reset = 1'b0;
      tick();

      // Spikes on samples 1 and 3 of a 4-sample window.
      pat = '0;
      pat[0] = 1'b1;
      pat[2] = 1'b1;
      run_window(4, pat, 0);

      // Zero length behaves as a single sample.
      pat = '0;
      pat[0] = 1'b1;
      run_window(0, pat, 0);

      // Full 255-sample window, spike every cycle.
      pat = '1;
      run_window(255, pat, 0);

      // Result held for 5 cycles with start and spikes toggling around it.
      pat = '0;
      pat[7:0] = 8'b1001_0110;
      run_window(8, pat, 5);

      // Widely spaced spikes and a silent window.
      pat = '0;
      pat[0]   = 1'b1;
      pat[199] = 1'b1;
      run_window(200, pat, 1);
      pat = '0;
      run_window(10, pat, 0);

      pat = '0;
      for (int i = 0; i < 40; i++) pat[i] = 1'($urandom_range(0, 1));
      run_window(40, pat, 2);

      // Reset at sample 2 of a 6-sample window discards the partial result.
      start      = 1'b1;
      window_len = 8'd6;
      spike_in   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_rate", {24'd0, rate_out}, 32'd0);
      check("mid_rst_isi", {24'd0, isi_min}, 32'hff);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("mid_rst_no_result", {31'd0, valid}, 32'd0);
      end
      spike_in = 1'b0;

      pat = '0;
      pat[0] = 1'b1;
      pat[1] = 1'b1;
      pat[5] = 1'b1;
      run_window(6, pat, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
